turn_ctrl: RTL and testbench

- Sequences one two-player card game: alternates P1/P2 card selection, validates each selection against the player's remaining hand and issues a one-cycle handout pulse to the matching per-player handout stage.
- Judges each round by card value, keeps scores and round count, and declares the winner after the last round.
- Sits between the switch/button input logic and the two per-player handout stages. It owns both 9-bit hand masks.

---
 rtl/turn_ctrl_if.sv | 41 ++++
 rtl/turn_ctrl.sv | 155 +++++++++++++++
 tb/tb_turn_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/turn_ctrl_if.sv
// turn_ctrl_if: signal bundle between the switch/button input logic (master)
// and the turn controller (slave).
//   start, confirm, cardselect        : requests from the input logic
//   p1_card, p2_card                   : remaining hand masks (1 = card held)
//   handout_p1_pulse, handout_p2_pulse : one-cycle strobes to the handout stages
//   p1_val, p2_val                     : value of each player's last played card
//   p1_score, p2_score, round          : game progress counters
//   active_player, invalid_sel         : selection status
//   game_over, winner                  : end-of-game result
interface turn_ctrl_if;
    logic       start;
    logic       confirm;
    logic [8:0] cardselect;
    logic [8:0] p1_card;
    logic [8:0] p2_card;
    logic       handout_p1_pulse;
    logic       handout_p2_pulse;
    logic [3:0] p1_val;
    logic [3:0] p2_val;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [3:0] round;
    logic       active_player;
    logic       invalid_sel;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output start, confirm, cardselect,
        input  p1_card, p2_card, handout_p1_pulse, handout_p2_pulse,
        input  p1_val, p2_val, p1_score, p2_score, round,
        input  active_player, invalid_sel, game_over, winner
    );

    modport slave (
        input  start, confirm, cardselect,
        output p1_card, p2_card, handout_p1_pulse, handout_p2_pulse,
        output p1_val, p2_val, p1_score, p2_score, round,
        output active_player, invalid_sel, game_over, winner
    );
endinterface

// File: rtl/turn_ctrl.sv
// turn_ctrl: sequences one two-player card game. Alternates P1/P2 card
// selection, validates each pick against the player's remaining hand, strobes
// the matching handout stage, judges each round and declares the winner.
// Ports:
//   clk    : system clock, rising edge
//   resetn : asynchronous reset, active-high (1 = clear)
//   bus    : turn_ctrl_if.slave (inputs start/confirm/cardselect, all status)
// Every output is a register or a decode of the state register.
module turn_ctrl #(
    parameter int ROUNDS = 9
) (
    input  logic        clk,
    input  logic        resetn,
    turn_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_P1_SEL, S_P1_OUT, S_P2_SEL, S_P2_OUT, S_JUDGE, S_DONE
    } state_t;

    localparam logic [3:0] ROUNDS_L = 4'(ROUNDS);

    state_t     state_q, state_d;
    logic [8:0] p1_card_q, p1_card_d, p2_card_q, p2_card_d;
    logic [3:0] p1_val_q, p1_val_d, p2_val_q, p2_val_d;
    logic [3:0] p1_score_q, p1_score_d, p2_score_q, p2_score_d;
    logic [3:0] round_q, round_d;
    logic       invalid_q, invalid_d;
    logic [1:0] winner_q, winner_d;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic is_onehot(input logic [8:0] x);
        return (x != 9'd0) && ((x & (x - 9'd1)) == 9'd0);
    endfunction

    function automatic logic [3:0] encode(input logic [8:0] x);
        logic [3:0] v;
        v = 4'd0;
        for (int k = 0; k < 9; k++) begin
            if (x[k]) v = 4'(k);
        end
        return v;
    endfunction

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q    <= S_IDLE;
            p1_card_q  <= 9'h1FF;
            p2_card_q  <= 9'h1FF;
            p1_val_q   <= 4'd0;
            p2_val_q   <= 4'd0;
            p1_score_q <= 4'd0;
            p2_score_q <= 4'd0;
            round_q    <= 4'd0;
            invalid_q  <= 1'b0;
            winner_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            p1_card_q  <= p1_card_d;
            p2_card_q  <= p2_card_d;
            p1_val_q   <= p1_val_d;
            p2_val_q   <= p2_val_d;
            p1_score_q <= p1_score_d;
            p2_score_q <= p2_score_d;
            round_q    <= round_d;
            invalid_q  <= invalid_d;
            winner_q   <= winner_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        p1_card_d  = p1_card_q;
        p2_card_d  = p2_card_q;
        p1_val_d   = p1_val_q;
        p2_val_d   = p2_val_q;
        p1_score_d = p1_score_q;
        p2_score_d = p2_score_q;
        round_d    = round_q;
        invalid_d  = 1'b0;
        winner_d   = winner_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // start has priority; confirm is never looked at here
                if (bus.start) begin
                    p1_card_d  = 9'h1FF;
                    p2_card_d  = 9'h1FF;
                    p1_val_d   = 4'd0;
                    p2_val_d   = 4'd0;
                    p1_score_d = 4'd0;
                    p2_score_d = 4'd0;
                    round_d    = 4'd0;
                    winner_d   = 2'b00;
                    state_d    = S_P1_SEL;
                end
            end
            S_P1_SEL: begin
                if (bus.confirm) begin
                    if (is_onehot(bus.cardselect) && ((bus.cardselect & p1_card_q) != 9'd0)) begin
                        p1_card_d = p1_card_q & ~bus.cardselect;
                        p1_val_d  = encode(bus.cardselect);
                        state_d   = S_P1_OUT;
                    end else begin
                        invalid_d = 1'b1;
                    end
                end
            end
            S_P1_OUT: state_d = S_P2_SEL;
            S_P2_SEL: begin
                if (bus.confirm) begin
                    if (is_onehot(bus.cardselect) && ((bus.cardselect & p2_card_q) != 9'd0)) begin
                        p2_card_d = p2_card_q & ~bus.cardselect;
                        p2_val_d  = encode(bus.cardselect);
                        state_d   = S_P2_OUT;
                    end else begin
                        invalid_d = 1'b1;
                    end
                end
            end
            S_P2_OUT: state_d = S_JUDGE;
            S_JUDGE: begin
                if (p1_val_q > p2_val_q) p1_score_d = p1_score_q + 4'd1;
                if (p2_val_q > p1_val_q) p2_score_d = p2_score_q + 4'd1;
                round_d = round_q + 4'd1;
                if (round_d == ROUNDS_L) begin
                    // Winner is latched from the post-judge scores on entry to DONE.
                    if (p1_score_d > p2_score_d)      winner_d = 2'b01;
                    else if (p2_score_d > p1_score_d) winner_d = 2'b10;
                    else                              winner_d = 2'b11;
                    state_d = S_DONE;
                end else begin
                    state_d = S_P1_SEL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.p1_card          = p1_card_q;
    assign bus.p2_card          = p2_card_q;
    assign bus.p1_val           = p1_val_q;
    assign bus.p2_val           = p2_val_q;
    assign bus.p1_score         = p1_score_q;
    assign bus.p2_score         = p2_score_q;
    assign bus.round            = round_q;
    assign bus.invalid_sel      = invalid_q;
    assign bus.winner           = winner_q;
    // Strobes decode straight from the state register, so reset drops them at once.
    assign bus.handout_p1_pulse = (state_q == S_P1_OUT);
    assign bus.handout_p2_pulse = (state_q == S_P2_OUT);
    assign bus.active_player    = (state_q == S_P2_SEL) || (state_q == S_P2_OUT);
    assign bus.game_over        = (state_q == S_DONE);

endmodule

// File: tb/tb_turn_ctrl.sv
// tb_turn_ctrl: directed and randomized stimulus for turn_ctrl, checked against
// a game-level reference model (hands, last values, scores, round count).
module tb_turn_ctrl;
    localparam int ROUNDS = 9;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    turn_ctrl_if bus();

    turn_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model of the game
    logic [8:0] m_hand [2];
    int         m_val  [2];
    int         m_score[2];
    int         m_round;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int p = 0; p < 2; p++) begin
            m_hand[p]  = 9'h1FF;
            m_val[p]   = 0;
            m_score[p] = 0;
        end
        m_round = 0;
    endtask

    function automatic int exp_winner();
        if (m_score[0] > m_score[1]) return 1;
        if (m_score[1] > m_score[0]) return 2;
        return 3;
    endfunction

    function automatic logic pulse_of(input int p);
        return (p == 0) ? bus.handout_p1_pulse : bus.handout_p2_pulse;
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, "_p1card"},  32'(bus.p1_card),  32'(m_hand[0]));
        chk({tag, "_p2card"},  32'(bus.p2_card),  32'(m_hand[1]));
        chk({tag, "_p1val"},   32'(bus.p1_val),   32'(m_val[0]));
        chk({tag, "_p2val"},   32'(bus.p2_val),   32'(m_val[1]));
        chk({tag, "_p1score"}, 32'(bus.p1_score), 32'(m_score[0]));
        chk({tag, "_p2score"}, 32'(bus.p2_score), 32'(m_score[1]));
        chk({tag, "_round"},   32'(bus.round),    32'(m_round));
    endtask

    task automatic do_start(input bit with_confirm);
        bus.start      = 1'b1;
        bus.confirm    = with_confirm;
        bus.cardselect = 9'h001;
        tick();
        bus.start   = 1'b0;
        bus.confirm = 1'b0;
        model_clear();
        check_regs("start");
        chk("start_active", 32'(bus.active_player), 32'd0);
        chk("start_over",   32'(bus.game_over),     32'd0);
        chk("start_winner", 32'(bus.winner),        32'd0);
        chk("start_inv",    32'(bus.invalid_sel),   32'd0);
    endtask

    // Submit one selection for player p (0 = P1) and follow it through the
    // handout cycle and, for P2, the judge cycle.
    task automatic select(input int p, input logic [8:0] sel, output bit accepted);
        bit valid;
        bus.cardselect = sel;
        bus.confirm    = 1'b1;
        tick();
        bus.confirm = 1'b0;
        valid = ($countones(sel) == 1) && ((sel & m_hand[p]) != 9'd0);
        accepted = valid;
        if (valid) begin
            m_hand[p] = m_hand[p] & ~sel;
            for (int k = 0; k < 9; k++) if (sel[k]) m_val[p] = k;
            chk("sel_pulse",  32'(pulse_of(p)),        32'd1);
            chk("sel_other",  32'(pulse_of(1 - p)),    32'd0);
            chk("sel_inv",    32'(bus.invalid_sel),    32'd0);
            chk("sel_active", 32'(bus.active_player),  32'(p));
            check_regs("sel");
            tick();
            chk("sel_pulse_end", 32'(pulse_of(p)), 32'd0);
            if (p == 1) begin
                tick();
                if (m_val[0] > m_val[1]) m_score[0]++;
                if (m_val[1] > m_val[0]) m_score[1]++;
                m_round++;
                check_regs("judge");
                chk("judge_over", 32'(bus.game_over), 32'(m_round == ROUNDS));
                if (m_round == ROUNDS)
                    chk("judge_winner", 32'(bus.winner), 32'(exp_winner()));
                else
                    chk("judge_active", 32'(bus.active_player), 32'd0);
            end else begin
                chk("sel_p2turn", 32'(bus.active_player), 32'd1);
            end
        end else begin
            chk("inv_flag", 32'(bus.invalid_sel),      32'd1);
            chk("inv_p1",   32'(bus.handout_p1_pulse), 32'd0);
            chk("inv_p2",   32'(bus.handout_p2_pulse), 32'd0);
            check_regs("inv");
            tick();
            chk("inv_flag_end", 32'(bus.invalid_sel), 32'd0);
        end
    endtask

    function automatic logic [8:0] pick_held(input int p);
        int s;
        s = $urandom_range(0, 8);
        for (int i = 0; i < 9; i++) begin
            if (m_hand[p][(s + i) % 9]) return 9'(1) << ((s + i) % 9);
        end
        return 9'd0;
    endfunction

    task automatic random_turn(input int p);
        bit acc;
        logic [8:0] sel;
        acc = 1'b0;
        for (int tries = 0; tries < 4 && !acc; tries++) begin
            if (tries < 3 && $urandom_range(0, 2) == 0) sel = 9'($urandom());
            else                                        sel = pick_held(p);
            select(p, sel, acc);
        end
    endtask

    task automatic finish_game();
        int guard;
        guard = 0;
        while (m_round < ROUNDS && guard < 20) begin
            random_turn(0);
            random_turn(1);
            guard++;
        end
    endtask

    initial begin
        bit acc;
        resetn         = 1'b1;
        bus.start      = 1'b0;
        bus.confirm    = 1'b0;
        bus.cardselect = 9'd0;
        model_clear();
        repeat (3) tick();
        resetn = 1'b0;
        tick();

        // Reset state
        check_regs("rst");
        chk("rst_p1pulse", 32'(bus.handout_p1_pulse), 32'd0);
        chk("rst_p2pulse", 32'(bus.handout_p2_pulse), 32'd0);
        chk("rst_inv",     32'(bus.invalid_sel),      32'd0);
        chk("rst_over",    32'(bus.game_over),        32'd0);
        chk("rst_winner",  32'(bus.winner),           32'd0);
        chk("rst_active",  32'(bus.active_player),    32'd0);

        // Confirm alone in IDLE is ignored
        bus.cardselect = 9'h001;
        bus.confirm    = 1'b1;
        tick();
        bus.confirm = 1'b0;
        chk("idle_conf_inv", 32'(bus.invalid_sel), 32'd0);
        check_regs("idle_conf");
        tick();

        // Start with confirm together: start wins, no card taken
        do_start(1'b1);

        // Round 1: P1 plays 8, P2 plays 2
        select(0, 9'h100, acc);
        select(1, 9'h004, acc);
        chk("t1_p1card",  32'(bus.p1_card),  32'h0FF);
        chk("t1_p2card",  32'(bus.p2_card),  32'h1FB);
        chk("t1_p1val",   32'(bus.p1_val),   32'd8);
        chk("t1_p2val",   32'(bus.p2_val),   32'd2);
        chk("t1_p1score", 32'(bus.p1_score), 32'd1);
        chk("t1_round",   32'(bus.round),    32'd1);

        // Multi-hot, empty and replayed selections are rejected
        select(0, 9'h003, acc);
        chk("t2_rej_multi", 32'(acc), 32'd0);
        select(0, 9'h000, acc);
        chk("t2_rej_zero", 32'(acc), 32'd0);
        select(0, 9'h100, acc);
        chk("t3_rej_used", 32'(acc), 32'd0);

        // Both play 5: tie round
        select(0, 9'h020, acc);
        select(1, 9'h020, acc);
        chk("t4_p1score", 32'(bus.p1_score), 32'd1);
        chk("t4_p2score", 32'(bus.p2_score), 32'd0);
        chk("t4_round",   32'(bus.round),    32'd2);

        // Confirm held two cycles in P1_SEL: only one card taken
        bus.cardselect = 9'h001;
        bus.confirm    = 1'b1;
        tick();
        chk("hold_pulse", 32'(bus.handout_p1_pulse), 32'd1);
        tick();
        bus.confirm = 1'b0;
        m_hand[0] = m_hand[0] & ~9'h001;
        m_val[0]  = 0;
        chk("hold_inv",    32'(bus.invalid_sel),   32'd0);
        chk("hold_active", 32'(bus.active_player), 32'd1);
        check_regs("hold");
        random_turn(1);
        finish_game();
        chk("gameA_over", 32'(bus.game_over), 32'd1);

        // Confirm in DONE is ignored
        bus.cardselect = 9'h001;
        bus.confirm    = 1'b1;
        tick();
        bus.confirm = 1'b0;
        chk("done_conf_inv", 32'(bus.invalid_sel), 32'd0);
        check_regs("done_conf");

        // Full game: P1 plays 8..0, P2 plays 0..8
        do_start(1'b0);
        for (int r = 0; r < ROUNDS; r++) begin
            select(0, 9'(1) << (8 - r), acc);
            select(1, 9'(1) << r, acc);
        end
        chk("full_p1score", 32'(bus.p1_score),  32'd4);
        chk("full_p2score", 32'(bus.p2_score),  32'd4);
        chk("full_winner",  32'(bus.winner),    32'd3);
        chk("full_over",    32'(bus.game_over), 32'd1);
        chk("full_p1card",  32'(bus.p1_card),   32'h000);
        chk("full_p2card",  32'(bus.p2_card),   32'h000);
        do_start(1'b0);
        chk("restart_p1card", 32'(bus.p1_card), 32'h1FF);

        // Random games
        finish_game();
        for (int g = 0; g < 3; g++) begin
            do_start(1'b0);
            finish_game();
            chk("rand_over", 32'(bus.game_over), 32'd1);
        end

        // Reset during P1_OUT
        do_start(1'b0);
        bus.cardselect = 9'h010;
        bus.confirm    = 1'b1;
        tick();
        bus.confirm = 1'b0;
        chk("rstmid_pulse", 32'(bus.handout_p1_pulse), 32'd1);
        #1 resetn = 1'b1;
        #1;
        chk("rstmid_drop", 32'(bus.handout_p1_pulse), 32'd0);
        model_clear();
        check_regs("rstmid");
        chk("rstmid_over",   32'(bus.game_over),     32'd0);
        chk("rstmid_active", 32'(bus.active_player), 32'd0);
        tick();
        resetn = 1'b0;
        tick();
        bus.cardselect = 9'h002;
        bus.confirm    = 1'b1;
        tick();
        bus.confirm = 1'b0;
        chk("rstmid_idle_inv",   32'(bus.invalid_sel),      32'd0);
        chk("rstmid_idle_pulse", 32'(bus.handout_p1_pulse), 32'd0);
        check_regs("rstmid_idle");
        tick();
        chk("rstmid_idle_pulse2", 32'(bus.handout_p1_pulse), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
